// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - selectable N-operand bitwise function behind a 2-stage valid/ready pipeline
// Stage 1 holds the raw result; stage 2 holds result plus reduction flags and drives out_*.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_all1,
  output logic                    out_all0,
  output logic                    out_par,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        txn_cnt,
  input  logic                    clr_cnt
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_ZERO = 3'd7
  } op_e;

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_func;
  logic             w_s2_load;
  logic             w_accept;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_data;
  logic             r_all1;
  logic             r_all0;
  logic             r_par;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_and = '1;
    w_or  = '0;
    w_xor = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_and = w_and & in_data[k*WIDTH +: WIDTH];
      w_or  = w_or  | in_data[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ in_data[k*WIDTH +: WIDTH];
    end
    w_func = '0;
    case (op_e'(in_op))
      OP_AND:  w_func = w_and;
      OP_OR:   w_func = w_or;
      OP_XOR:  w_func = w_xor;
      OP_NAND: w_func = ~w_and;
      OP_NOR:  w_func = ~w_or;
      OP_XNOR: w_func = ~w_xor;
      OP_PASS: w_func = in_data[WIDTH-1:0];
      OP_ZERO: w_func = '0;
      default: w_func = '0;
    endcase
  end

  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= w_func;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // On a bubble only the valid drops; data and flags keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_all1     <= 1'b0;
      r_all0     <= 1'b0;
      r_par      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= r_s1_data;
        r_all1    <= &r_s1_data;
        r_all0    <= ~|r_s1_data;
        r_par     <= ^r_s1_data;
      end
    end
  end

  // Clear takes priority over a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_all1  = r_all1;
  assign out_all0  = r_all0;
  assign out_par   = r_par;
  assign txn_cnt   = r_cnt;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - scoreboard bench for logic_gate_pipe (2-operand/3-bit-count and 3-operand instances)
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] a_in_data;
  logic [2:0]  a_in_op;
  logic        a_in_valid, a_in_ready, a_out_ready, a_clr;
  logic [7:0]  a_out_data;
  logic        a_all1, a_all0, a_par, a_out_valid;
  logic [2:0]  a_cnt;

  logic [23:0] b_in_data;
  logic [2:0]  b_in_op;
  logic        b_in_valid, b_in_ready, b_out_ready, b_clr;
  logic [7:0]  b_out_data;
  logic        b_all1, b_all0, b_par, b_out_valid;
  logic [15:0] b_cnt;

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_op(a_in_op),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_all1(a_all1), .out_all0(a_all0), .out_par(a_par),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .txn_cnt(a_cnt),
    .clr_cnt(a_clr));

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_op(b_in_op),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_all1(b_all1), .out_all0(b_all0), .out_par(b_par),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .txn_cnt(b_cnt),
    .clr_cnt(b_clr));

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic       a_stall = 1'b0, b_stall = 1'b0;
  logic [7:0] a_prev, b_prev, e_a, e_b;

  function automatic logic [7:0] model(input logic [2:0] op, input logic [23:0] d, input int n);
    logic [7:0] f_and, f_or, f_xor;
    f_and = 8'hFF;
    f_or  = 8'h00;
    f_xor = 8'h00;
    for (int k = 0; k < n; k++) begin
      f_and = f_and & d[k*8 +: 8];
      f_or  = f_or  | d[k*8 +: 8];
      f_xor = f_xor ^ d[k*8 +: 8];
    end
    case (op)
      3'd0: return f_and;
      3'd1: return f_or;
      3'd2: return f_xor;
      3'd3: return ~f_and;
      3'd4: return ~f_or;
      3'd5: return ~f_xor;
      3'd6: return d[7:0];
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_stall) begin
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== a_prev) begin
          n_fail++;
          $display("FAIL a_stall_hold: valid=%b data=%h, required valid=1 data=%h", a_out_valid, a_out_data, a_prev);
        end
      end
      if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
        n_checks++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL a_unexpected_out: data=%h, required no output", a_out_data);
        end else begin
          e_a = q_a.pop_front();
          if ({a_out_data, a_all1, a_all0, a_par} !== {e_a, &e_a, ~|e_a, ^e_a}) begin
            n_fail++;
            $display("FAIL a_out: data=%h all1=%b all0=%b par=%b, required data=%h all1=%b all0=%b par=%b",
                     a_out_data, a_all1, a_all0, a_par, e_a, &e_a, ~|e_a, ^e_a);
          end
        end
      end
      a_stall = (a_out_valid === 1'b1) && (a_out_ready !== 1'b1);
      a_prev  = a_out_data;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_stall) begin
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== b_prev) begin
          n_fail++;
          $display("FAIL b_stall_hold: valid=%b data=%h, required valid=1 data=%h", b_out_valid, b_out_data, b_prev);
        end
      end
      if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
        n_checks++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected_out: data=%h, required no output", b_out_data);
        end else begin
          e_b = q_b.pop_front();
          if ({b_out_data, b_all1, b_all0, b_par} !== {e_b, &e_b, ~|e_b, ^e_b}) begin
            n_fail++;
            $display("FAIL b_out: data=%h all1=%b all0=%b par=%b, required data=%h all1=%b all0=%b par=%b",
                     b_out_data, b_all1, b_all0, b_par, e_b, &e_b, ~|e_b, ^e_b);
          end
        end
      end
      b_stall = (b_out_valid === 1'b1) && (b_out_ready !== 1'b1);
      b_prev  = b_out_data;
    end
  end

  task automatic idle_inputs();
    a_in_data = '0; a_in_op = '0; a_in_valid = 0; a_out_ready = 1; a_clr = 0;
    b_in_data = '0; b_in_op = '0; b_in_valid = 0; b_out_ready = 1; b_clr = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    q_a.delete(); q_b.delete();
    a_stall = 0; b_stall = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic drain_b(input int budget);
    b_in_valid = 0;
    b_out_ready = 1;
    for (int i = 0; i < budget && q_b.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (q_b.size() != 0) begin
      n_fail++;
      $display("FAIL b_drain: %0d results outstanding, required 0", q_b.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({a_out_valid, a_out_data, a_all1, a_all0, a_par, a_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: valid=%b data=%h flags=%b%b%b cnt=%0d, required all 0",
               a_out_valid, a_out_data, a_all1, a_all0, a_par, a_cnt);
    end
    n_checks++;
    if ({b_out_valid, b_out_data, b_all1, b_all0, b_par, b_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: valid=%b data=%h flags=%b%b%b cnt=%0d, required all 0",
               b_out_valid, b_out_data, b_all1, b_all0, b_par, b_cnt);
    end
    rst_n = 1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: a=%b b=%b, required 1 1", a_in_ready, b_in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_and();
    apply_reset();
    a_in_data = {8'hF0, 8'h3C};
    a_in_op = 3'd0;
    a_in_valid = 1;
    a_out_ready = 1;
    @(negedge clk);
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL and_accept: in_ready=%b, required 1", a_in_ready);
    end
    q_a.push_back(8'h30);
    @(posedge clk); #1;
    a_in_valid = 0;
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL and_early: out_valid=%b, required 0 one cycle after accept", a_out_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({a_out_valid, a_out_data, a_all1, a_all0, a_par} !== {1'b1, 8'h30, 3'b000}) begin
      n_fail++;
      $display("FAIL and_result: valid=%b data=%h flags=%b%b%b, required valid=1 data=30 flags=000",
               a_out_valid, a_out_data, a_all1, a_all0, a_par);
    end
    n_checks++;
    if (a_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL and_cnt: txn_cnt=%0d, required 1", a_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_t [8];
    exp_t = '{8'h05, 8'hFF, 8'hA5, 8'hFA, 8'h00, 8'h5A, 8'h55, 8'h00};
    apply_reset();
    b_in_data = {8'hFF, 8'h0F, 8'h55};
    b_out_ready = 1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      b_in_valid = (cyc < 8);
      b_in_op = 3'(cyc);
      @(negedge clk);
      if (cyc < 8) begin
        n_checks++;
        if (b_in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL sweep_in_ready: op=%0d in_ready=%b, required 1", cyc, b_in_ready);
        end
        q_b.push_back(exp_t[cyc]);
      end
      if (cyc >= 2) begin
        n_checks++;
        if ({b_out_valid, b_out_data, b_all0, b_all1} !==
            {1'b1, exp_t[cyc-2], (cyc-2 == 4 || cyc-2 == 7), (cyc-2 == 1)}) begin
          n_fail++;
          $display("FAIL sweep_op%0d: valid=%b data=%h all0=%b all1=%b, required valid=1 data=%h all0=%b all1=%b",
                   cyc-2, b_out_valid, b_out_data, b_all0, b_all1, exp_t[cyc-2],
                   (cyc-2 == 4 || cyc-2 == 7), (cyc-2 == 1));
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (b_out_valid !== 1'b0 || b_out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL sweep_bubble: valid=%b data=%h, required valid=0 data=00 held", b_out_valid, b_out_data);
    end
    drain_b(5);
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic [7:0] first = '0;
    apply_reset();
    for (int cyc = 0; cyc < 40 && acc < 5; cyc++) begin
      b_out_ready = (cyc >= 4);
      b_in_valid = 1;
      b_in_data = 24'($urandom);
      b_in_op = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        n_checks++;
        if (b_in_ready !== 1'b0 || acc != 2) begin
          n_fail++;
          $display("FAIL bp_refuse: cyc=%0d in_ready=%b accepts=%0d, required in_ready=0 accepts=2", cyc, b_in_ready, acc);
        end
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== first) begin
          n_fail++;
          $display("FAIL bp_hold: cyc=%0d valid=%b data=%h, required valid=1 data=%h", cyc, b_out_valid, b_out_data, first);
        end
      end
      if (b_in_ready === 1'b1) begin
        if (acc == 0) first = model(b_in_op, b_in_data, 3);
        q_b.push_back(model(b_in_op, b_in_data, 3));
        acc++;
      end
      @(posedge clk); #1;
    end
    drain_b(20);
    n_checks++;
    if (b_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL bp_cnt: txn_cnt=%0d, required 5", b_cnt);
    end
  endtask

  task automatic test_saturate_clear();
    apply_reset();
    a_out_ready = 1;
    for (int i = 1; i <= 9; i++) begin
      a_in_valid = 1;
      a_in_data = 16'($urandom);
      a_in_op = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (a_in_ready === 1'b1) q_a.push_back(model(a_in_op, {8'h00, a_in_data}, 2));
      @(posedge clk); #1;
      n_checks++;
      if (a_cnt !== 3'((i > 7) ? 7 : i)) begin
        n_fail++;
        $display("FAIL sat_cnt: accept %0d txn_cnt=%0d, required %0d", i, a_cnt, (i > 7) ? 7 : i);
      end
    end
    a_clr = 1;
    a_in_data = {8'hAA, 8'h0F};
    a_in_op = 3'd1;
    @(negedge clk);
    if (a_in_ready === 1'b1) q_a.push_back(8'hAF);
    @(posedge clk); #1;
    a_clr = 0;
    n_checks++;
    if (a_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL clr_wins: txn_cnt=%0d, required 0", a_cnt);
    end
    a_in_data = {8'h12, 8'h34};
    a_in_op = 3'd2;
    @(negedge clk);
    if (a_in_ready === 1'b1) q_a.push_back(8'h26);
    @(posedge clk); #1;
    a_in_valid = 0;
    n_checks++;
    if (a_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL clr_restart: txn_cnt=%0d, required 1", a_cnt);
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (q_a.size() != 0) begin
      n_fail++;
      $display("FAIL a_drain: %0d results outstanding, required 0", q_a.size());
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    b_out_ready = 0;
    b_in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      b_in_data = 24'($urandom);
      b_in_op = 3'($urandom_range(0, 6));
      @(negedge clk);
      if (b_in_ready === 1'b1) q_b.push_back(model(b_in_op, b_in_data, 3));
      @(posedge clk); #1;
    end
    b_in_valid = 0;
    #2;
    rst_n = 0;
    q_b.delete();
    b_stall = 0;
    #1;
    n_checks++;
    if (b_out_valid !== 1'b0 || b_cnt !== 16'd0 || b_out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL arst_immediate: valid=%b cnt=%0d data=%h, required 0 0 00", b_out_valid, b_cnt, b_out_data);
    end
    rst_n = 1;
    b_out_ready = 1;
    #0;
    n_checks++;
    if (b_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_in_ready: in_ready=%b, required 1", b_in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (b_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_stale: cycle %0d out_valid=%b, required 0", i, b_out_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int acc = 0;
    apply_reset();
    for (int cyc = 0; cyc < 20000 && acc < 1000; cyc++) begin
      b_in_valid = ($urandom_range(0, 9) < 7);
      b_in_data = 24'($urandom);
      b_in_op = 3'($urandom_range(0, 7));
      b_out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (b_in_valid && b_in_ready === 1'b1) begin
        q_b.push_back(model(b_in_op, b_in_data, 3));
        acc++;
      end
      @(posedge clk); #1;
    end
    drain_b(50);
    n_checks++;
    if (acc != 1000 || b_cnt !== 16'(acc)) begin
      n_fail++;
      $display("FAIL rand_cnt: accepts=%0d txn_cnt=%0d, required 1000 1000", acc, b_cnt);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_and();
    test_op_sweep();
    test_backpressure();
    test_saturate_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
